// File: rtl/agg_sched_pkg.sv
// agg_sched_pkg: shared types and helpers for the aggregation bank scheduler.
//   bank_state_t : per-bank lifecycle EMPTY -> LOADING -> FULL -> COMPUTING -> RESULT
//   BANK_A/B     : bank-select encodings (also the datapath S1/S2 select)
//   row_half     : lane-B first row (rows >> 1); lane B takes the odd extra row
package agg_sched_pkg;

    typedef enum logic [2:0] {
        EMPTY     = 3'd0,
        LOADING   = 3'd1,
        FULL      = 3'd2,
        COMPUTING = 3'd3,
        RESULT    = 3'd4
    } bank_state_t;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    function automatic logic [31:0] row_half(input logic [31:0] rows);
        return rows >> 1;
    endfunction

endpackage

// File: rtl/agg_bank_fsm.sv
// agg_bank_fsm: lifecycle state and stored row count of one ping-pong bank.
// The parent decides every transition and presents it as a one-cycle strobe;
// this block only applies it, so the strobes need no further qualification.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   grant             EMPTY/RESULT(+ack) -> LOADING
//   load, rows_in     LOADING -> FULL, captures rows_in
//   start             FULL -> COMPUTING
//   skip              FULL -> RESULT (zero-row block, no engine pass)
//   finish            COMPUTING -> RESULT
//   ack               RESULT -> EMPTY (or straight to LOADING with grant)
//   state, state_nxt  current and next state (bank_state_t encoding)
//   rows              stored row count
module agg_bank_fsm #(
    parameter int ROW_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             grant,
    input  logic             load,
    input  logic             start,
    input  logic             skip,
    input  logic             finish,
    input  logic             ack,
    input  logic [ROW_W-1:0] rows_in,
    output logic [2:0]       state,
    output logic [2:0]       state_nxt,
    output logic [ROW_W-1:0] rows
);
    import agg_sched_pkg::*;

    bank_state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= EMPTY;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:     if (grant)  state_d = LOADING;
            LOADING:   if (load)   state_d = FULL;
            FULL: begin
                if (start)     state_d = COMPUTING;
                else if (skip) state_d = RESULT;
            end
            COMPUTING: if (finish) state_d = RESULT;
            // an ack and a grant in the same cycle hand the bank straight back
            RESULT:    if (ack)    state_d = grant ? LOADING : EMPTY;
            default:               state_d = EMPTY;
        endcase
    end

    always_comb begin
        state     = state_q;
        state_nxt = state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst)      rows <= '0;
        else if (load) rows <= rows_in;
    end

endmodule

// File: rtl/aggregation_bank_sched.sv
// aggregation_bank_sched: ping-pong scheduler for the double-buffered
// aggregation banks. Grants the idle bank to the loader, starts the engine on
// a filled bank with a two-lane row split, holds results until acknowledged,
// and keeps load/compute/drain in strict A,B,A,... order.
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   ld_req / ld_grant / ld_bank       loader request, grant pulse, granted bank
//   ld_done / ld_rows                 load complete pulse and block row count
//   cmp_start / cmp_bank              engine start pulse, datapath bank select
//   cmp_start_a/_b / cmp_end          lane A/B first row, end row
//   cmp_done                          engine complete pulse
//   res_valid / res_bank / res_ack    result bank handshake
//   err                               sticky error (row overflow / protocol)
// Optional: define AGG_SCHED_PERF_EN to add perf_busy, perf_stall_ld and
// perf_stall_res saturating 32-bit counters.
module aggregation_bank_sched #(
    parameter int K     = 1024,
    parameter int ROW_W = $clog2(K + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_req,
    output logic             ld_grant,
    output logic             ld_bank,
    input  logic             ld_done,
    input  logic [ROW_W-1:0] ld_rows,
    output logic             cmp_start,
    output logic             cmp_bank,
    output logic [ROW_W-1:0] cmp_start_a,
    output logic [ROW_W-1:0] cmp_start_b,
    output logic [ROW_W-1:0] cmp_end,
    input  logic             cmp_done,
    output logic             res_valid,
    output logic             res_bank,
    input  logic             res_ack,
`ifdef AGG_SCHED_PERF_EN
    output logic [31:0]      perf_busy,
    output logic [31:0]      perf_stall_ld,
    output logic [31:0]      perf_stall_res,
`endif
    output logic             err
);
    import agg_sched_pkg::*;

    localparam logic [ROW_W-1:0] K_ROWS = ROW_W'(K);

    logic [2:0]       st     [2];
    logic [2:0]       st_nxt [2];
    logic [ROW_W-1:0] rows_q [2];

    logic ld_ptr, cmp_ptr, res_ptr, busy;

    logic             ack_ok, ld_any, ld_slot, ld_ok, done_ok, eng_free;
    logic             cmp_full, cmp_zero, skip, start, tgt_free, grant;
    logic             res_ptr_nxt, err_set;
    logic [ROW_W-1:0] rows_clamped;

    always_comb begin
        ack_ok   = res_ack && res_valid;
        // at most one bank can be LOADING: a grant needs none outstanding
        ld_any   = (st[BANK_A] == LOADING) || (st[BANK_B] == LOADING);
        ld_slot  = (st[BANK_B] == LOADING) ? BANK_B : BANK_A;
        ld_ok    = ld_done && ld_any;
        done_ok  = cmp_done && busy;
        // a finishing engine can take the next bank on the very next cycle
        eng_free = !busy || done_ok;
        cmp_full = (st[cmp_ptr] == FULL);
        cmp_zero = (rows_q[cmp_ptr] == '0);
        // zero-row blocks bypass the engine, so they do not wait for it
        skip     = cmp_full && cmp_zero;
        start    = cmp_full && !cmp_zero && eng_free;
        // an ack this cycle frees the bank before the grant check sees it
        tgt_free = (st[ld_ptr] == EMPTY) || (ack_ok && (res_ptr == ld_ptr));
        grant    = ld_req && !ld_any && tgt_free;
        rows_clamped = (ld_rows > K_ROWS) ? K_ROWS : ld_rows;
        res_ptr_nxt  = ack_ok ? ~res_ptr : res_ptr;
        err_set  = (ld_done && (!ld_any || (ld_rows > K_ROWS)))
                 || (cmp_done && !busy)
                 || (res_ack && !res_valid);
    end

    for (genvar i = 0; i < 2; i++) begin : g_bank
        agg_bank_fsm #(.ROW_W(ROW_W)) u_bank (
            .clk       (clk),
            .rst       (rst),
            .grant     (grant   && (ld_ptr   == 1'(i))),
            .load      (ld_ok   && (ld_slot  == 1'(i))),
            .start     (start   && (cmp_ptr  == 1'(i))),
            .skip      (skip    && (cmp_ptr  == 1'(i))),
            .finish    (done_ok && (cmp_bank == 1'(i))),
            .ack       (ack_ok  && (res_ptr  == 1'(i))),
            .rows_in   (rows_clamped),
            .state     (st[i]),
            .state_nxt (st_nxt[i]),
            .rows      (rows_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_grant    <= 1'b0;
            ld_bank     <= BANK_A;
            ld_ptr      <= BANK_A;
            cmp_start   <= 1'b0;
            cmp_bank    <= BANK_A;
            cmp_ptr     <= BANK_A;
            cmp_start_a <= '0;
            cmp_start_b <= '0;
            cmp_end     <= '0;
            busy        <= 1'b0;
            res_ptr     <= BANK_A;
            res_valid   <= 1'b0;
            err         <= 1'b0;
        end else begin
            ld_grant <= grant;
            if (grant) begin
                ld_bank <= ld_ptr;
                ld_ptr  <= ~ld_ptr;
            end
            cmp_start <= start;
            // cmp_bank and the row window only move on a real start
            if (start) begin
                cmp_bank    <= cmp_ptr;
                cmp_start_a <= '0;
                cmp_start_b <= ROW_W'(row_half(32'(rows_q[cmp_ptr])));
                cmp_end     <= rows_q[cmp_ptr];
            end
            if (start || skip) cmp_ptr <= ~cmp_ptr;
            if (start)        busy <= 1'b1;
            else if (done_ok) busy <= 1'b0;
            res_ptr   <= res_ptr_nxt;
            res_valid <= (st_nxt[res_ptr_nxt] == RESULT);
            if (err_set) err <= 1'b1;
        end
    end

    assign res_bank = res_ptr;

`ifdef AGG_SCHED_PERF_EN
    logic stall_ld_now, stall_res_now;
    assign stall_ld_now  = !busy && ((st[cmp_ptr] == EMPTY) || (st[cmp_ptr] == LOADING));
    assign stall_res_now = ld_req && !grant && (st[ld_ptr] == RESULT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_busy      <= '0;
            perf_stall_ld  <= '0;
            perf_stall_res <= '0;
        end else begin
            if (busy && (perf_busy != '1))              perf_busy      <= perf_busy + 32'd1;
            if (stall_ld_now && (perf_stall_ld != '1))  perf_stall_ld  <= perf_stall_ld + 32'd1;
            if (stall_res_now && (perf_stall_res != '1)) perf_stall_res <= perf_stall_res + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aggregation_bank_sched.sv
// Self-checking bench for aggregation_bank_sched: a cycle-level behavioural
// model of the bank lifecycle rules predicts every output each cycle, plus
// directed scenarios with literal expectations and randomized agents.
module tb_aggregation_bank_sched;

    localparam int K  = 1024;
    localparam int RW = 11;

    localparam int S_EMPTY = 0, S_LOADING = 1, S_FULL = 2, S_COMP = 3, S_RESULT = 4;

    logic          clk = 1'b0;
    logic          rst, ld_req, ld_done, cmp_done, res_ack;
    logic [RW-1:0] ld_rows;
    logic          ld_grant, ld_bank, cmp_start, cmp_bank, res_valid, res_bank, err;
    logic [RW-1:0] cmp_start_a, cmp_start_b, cmp_end;

    aggregation_bank_sched #(.K(K)) dut (
        .clk(clk), .rst(rst), .ld_req(ld_req), .ld_grant(ld_grant), .ld_bank(ld_bank),
        .ld_done(ld_done), .ld_rows(ld_rows), .cmp_start(cmp_start), .cmp_bank(cmp_bank),
        .cmp_start_a(cmp_start_a), .cmp_start_b(cmp_start_b), .cmp_end(cmp_end),
        .cmp_done(cmp_done), .res_valid(res_valid), .res_bank(res_bank),
        .res_ack(res_ack), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;

    // ---- behavioural model ----
    int            mst [2];
    int            mrows [2];
    bit            mlp, mcp, mrp, mbusy, mcb;
    bit            e_grant, e_lbank, e_start, e_cbank, e_rv, e_err;
    logic [RW-1:0] e_a, e_b, e_end;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin mst[i] = S_EMPTY; mrows[i] = 0; end
        mlp = 0; mcp = 0; mrp = 0; mbusy = 0; mcb = 0;
        e_grant = 0; e_lbank = 0; e_start = 0; e_cbank = 0; e_rv = 0; e_err = 0;
        e_a = '0; e_b = '0; e_end = '0;
    endtask

    task automatic model_step();
        int ns [2];
        bit ack_ok, eng_free, rp_old;
        int b;
        if (!rst) begin model_reset(); return; end
        ns = mst;
        e_grant = 0; e_start = 0;
        rp_old = mrp;
        ack_ok = res_ack && e_rv;
        if (res_ack && !e_rv) e_err = 1;
        if (ack_ok) begin ns[mrp] = S_EMPTY; mrp = ~mrp; end
        if (ld_done) begin
            if (int'(ld_rows) > K) e_err = 1;
            if (mst[0] == S_LOADING || mst[1] == S_LOADING) begin
                b = (mst[1] == S_LOADING) ? 1 : 0;
                ns[b] = S_FULL;
                mrows[b] = (int'(ld_rows) > K) ? K : int'(ld_rows);
            end else e_err = 1;
        end
        eng_free = !mbusy;
        if (cmp_done) begin
            if (mbusy) begin ns[mcb] = S_RESULT; mbusy = 0; eng_free = 1; end
            else e_err = 1;
        end
        if (mst[mcp] == S_FULL) begin
            if (mrows[mcp] == 0) begin
                ns[mcp] = S_RESULT; mcp = ~mcp;
            end else if (eng_free) begin
                ns[mcp] = S_COMP; e_start = 1; e_cbank = mcp; mcb = mcp; mbusy = 1;
                e_a = '0; e_b = RW'(mrows[mcp] / 2); e_end = RW'(mrows[mcp]);
                mcp = ~mcp;
            end
        end
        if (ld_req && mst[0] != S_LOADING && mst[1] != S_LOADING &&
            (mst[mlp] == S_EMPTY || (ack_ok && rp_old == mlp))) begin
            ns[mlp] = S_LOADING; e_grant = 1; e_lbank = mlp; mlp = ~mlp;
        end
        mst = ns;
        e_rv = (mst[mrp] == S_RESULT);
    endtask

    function automatic logic [39:0] outs();
        return {ld_grant, ld_bank, cmp_start, cmp_bank, cmp_start_a, cmp_start_b,
                cmp_end, res_valid, res_bank, err};
    endfunction

    task automatic compare_all();
        logic [39:0] exp;
        exp = {e_grant, e_lbank, e_start, e_cbank, e_a, e_b, e_end, e_rv, mrp, e_err};
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL model cyc=%0d got grant=%0d lbank=%0d start=%0d cbank=%0d a=%0d b=%0d end=%0d rv=%0d rb=%0d err=%0d exp grant=%0d lbank=%0d start=%0d cbank=%0d a=%0d b=%0d end=%0d rv=%0d rb=%0d err=%0d",
                     cyc, ld_grant, ld_bank, cmp_start, cmp_bank, cmp_start_a, cmp_start_b, cmp_end,
                     res_valid, res_bank, err, e_grant, e_lbank, e_start, e_cbank, e_a, e_b, e_end,
                     e_rv, mrp, e_err);
        end
    endtask

    task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    // ---- randomized agents ----
    int ld_wait = 0, cmp_wait = 0;

    task automatic clear_inputs();
        ld_req = 0; ld_done = 0; ld_rows = '0; cmp_done = 0; res_ack = 0;
        ld_wait = 0; cmp_wait = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 0;
        tick(); tick();
        rst = 1;
    endtask

    function automatic logic [RW-1:0] pick_rows();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0)      return '0;
        else if (r == 1) return RW'(K + $urandom_range(1, 900));
        else             return RW'($urandom_range(1, 40));
    endfunction

    task automatic agents(input bit viol);
        ld_done = 0; cmp_done = 0; res_ack = 0;
        ld_req = ($urandom_range(0, 3) != 0);
        if (ld_grant) ld_wait = $urandom_range(1, 5);
        if (ld_wait > 0) begin
            ld_wait--;
            if (ld_wait == 0) begin ld_done = 1; ld_rows = pick_rows(); end
        end
        if (cmp_start) cmp_wait = $urandom_range(1, 5);
        if (cmp_wait > 0) begin
            cmp_wait--;
            if (cmp_wait == 0) cmp_done = 1;
        end
        if (res_valid && $urandom_range(0, 2) == 0) res_ack = 1;
        if (viol) begin
            if ($urandom_range(0, 24) == 0) begin ld_done = 1; ld_rows = pick_rows(); end
            if ($urandom_range(0, 24) == 0) cmp_done = 1;
            if ($urandom_range(0, 24) == 0) res_ack = 1;
        end
    endtask

    initial begin
        bit hit;
        clear_inputs();
        rst = 0;
        model_reset();
        do_reset();
        check_lit("reset_state", 64'(outs()), 64'd0);

        // single block, rows=10
        ld_req = 1; tick();
        check_lit("t1_grant_a", {ld_grant, ld_bank}, 2'b10);
        ld_req = 0; ld_done = 1; ld_rows = 11'd10; tick();
        ld_done = 0; tick();
        check_lit("t1_start", {cmp_start, cmp_bank, cmp_start_a, cmp_start_b, cmp_end},
                  {1'b1, 1'b0, 11'd0, 11'd5, 11'd10});
        cmp_done = 1; tick();
        cmp_done = 0;
        check_lit("t1_result", {res_valid, res_bank, cmp_start}, 3'b100);
        res_ack = 1; tick();
        res_ack = 0;
        check_lit("t1_drained", {res_valid, err}, 2'b00);

        // rows=0 on A, rows=7 on B
        do_reset();
        ld_req = 1; tick();
        ld_req = 0; ld_done = 1; ld_rows = 11'd0; tick();
        ld_done = 0; ld_req = 1; tick();
        check_lit("z_skip", {res_valid, res_bank, cmp_start, ld_grant, ld_bank}, 5'b10011);
        ld_req = 0; ld_done = 1; ld_rows = 11'd7; tick();
        ld_done = 0; tick();
        check_lit("z_b7", {cmp_start, cmp_bank, cmp_start_b, cmp_end}, {1'b1, 1'b1, 11'd3, 11'd7});
        res_ack = 1; cmp_done = 1; tick();
        res_ack = 0; cmp_done = 0;
        check_lit("z_res_b", {res_valid, res_bank}, 2'b11);
        res_ack = 1; tick();
        res_ack = 0;

        // ld_rows above K: clamp and flag
        do_reset();
        ld_req = 1; tick();
        ld_req = 0; ld_done = 1; ld_rows = 11'(K + 5); tick();
        ld_done = 0;
        check_lit("big_err", 64'(err), 64'd1);
        tick();
        check_lit("big_clamp", {cmp_start, cmp_start_b, cmp_end}, {1'b1, 11'd512, 11'd1024});
        cmp_done = 1; tick();
        cmp_done = 0; res_ack = 1; tick();
        res_ack = 0;

        // protocol violations
        do_reset();
        cmp_done = 1; tick();
        cmp_done = 0;
        check_lit("spur_done", {err, ld_grant, cmp_start, res_valid}, 4'b1000);
        res_ack = 1; tick();
        res_ack = 0;
        check_lit("spur_ack", {err, res_valid, res_bank}, 3'b100);
        ld_done = 1; ld_rows = 11'd4; tick();
        ld_done = 0; ld_req = 1; tick();
        check_lit("spur_ld_then_grant", {ld_grant, ld_bank, err}, 3'b101);

        // randomized streaming: clean, then with violations
        do_reset();
        for (int i = 0; i < 500; i++) begin agents(1'b0); tick(); end
        for (int i = 0; i < 300; i++) begin agents(1'b1); tick(); end

        // reset while bank B computes
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            agents(1'b0); tick();
            if (mbusy && mcb == 1'b1) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL busy_b_timeout got no B compute exp one within 2000 cycles");
        end
        clear_inputs();
        rst = 0; tick();
        check_lit("rst_mid", 64'(outs()), 64'd0);
        rst = 1;
        ld_req = 1; tick();
        check_lit("fresh_grant", {ld_grant, ld_bank}, 2'b10);
        ld_req = 0; ld_done = 1; ld_rows = 11'd3; tick();
        ld_done = 0; tick();
        check_lit("fresh_start", {cmp_start, cmp_bank, cmp_start_b, cmp_end}, {1'b1, 1'b0, 11'd1, 11'd3});
        cmp_done = 1; tick();
        cmp_done = 0;
        check_lit("fresh_res", {res_valid, res_bank, err}, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
